// File: rtl/ksz_bus_master.sv
// KSZ8851 16-bit host-bus master: turns one register request into a CMD phase
// (byte-enables + address) followed by a DATA phase, then reports completion.
module ksz_bus_master #(
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned RECOVER_CYC = 1,
  parameter int unsigned GAP_CYC     = 1
) (
  input  logic        clk40m,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        CMD,
  output logic        RDN,
  output logic        WRN,
  inout  wire  [15:0] SD
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_STB,
    S_CMD_REC,
    S_DAT_STB,
    S_DAT_REC,
    S_GAP
  } state_t;

  localparam logic [3:0] STB_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] REC_LD = 4'(RECOVER_CYC - 1);
  localparam logic [3:0] GAP_LD = 4'(GAP_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_done;
  logic        w_accept;
  logic        r_write;
  logic [7:0]  r_addr;
  logic [15:0] r_wdata;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [15:0] r_rdata;
  logic        w_oe;
  logic [15:0] w_sd_out;
  logic [15:0] w_cmd_word;

  assign w_cmd_word = {(r_addr[1] ? 4'b1100 : 4'b0011), 4'h0, r_addr};

  // Each state loads the counter with its duration-1 on entry and exits at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_done      = (r_cnt == '0);
    if (!w_done) w_cnt_nxt = r_cnt - 4'd1;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (req_addr[0]) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LD;
          end else begin
            w_state_nxt = S_CMD_STB;
            w_cnt_nxt   = STB_LD;
          end
        end
      end
      S_CMD_STB: if (w_done) begin w_state_nxt = S_CMD_REC; w_cnt_nxt = REC_LD; end
      S_CMD_REC: if (w_done) begin w_state_nxt = S_DAT_STB; w_cnt_nxt = STB_LD; end
      S_DAT_STB: if (w_done) begin w_state_nxt = S_DAT_REC; w_cnt_nxt = REC_LD; end
      S_DAT_REC: if (w_done) begin w_state_nxt = S_GAP;     w_cnt_nxt = GAP_LD; end
      S_GAP:     if (w_done) begin w_state_nxt = S_IDLE;    w_cnt_nxt = '0;     end
      default:   begin w_state_nxt = S_IDLE; w_cnt_nxt = '0; end
    endcase
  end

  // Pin decode is purely from state so reset drops strobes and SD asynchronously.
  always_comb begin
    CMD      = 1'b1;
    RDN      = 1'b1;
    WRN      = 1'b1;
    w_oe     = 1'b0;
    w_sd_out = w_cmd_word;
    case (r_state)
      S_CMD_STB: begin WRN = 1'b0; w_oe = 1'b1; end
      S_CMD_REC: w_oe = 1'b1;
      S_DAT_STB: begin
        CMD      = 1'b0;
        WRN      = ~r_write;
        RDN      = r_write;
        w_oe     = r_write;
        w_sd_out = r_wdata;
      end
      S_DAT_REC: begin
        CMD      = 1'b0;
        w_oe     = r_write;
        w_sd_out = r_wdata;
      end
      default: ;
    endcase
  end

  assign SD        = (w_oe && RDN) ? w_sd_out : 'z;
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rdata;

  always_ff @(posedge clk40m or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      r_rsp_valid <= (w_state_nxt == S_GAP) && (r_state != S_GAP);
      r_rsp_err   <= (w_state_nxt == S_GAP) && (r_state == S_IDLE);
      if (r_state == S_DAT_STB && w_done && !r_write) r_rdata <= SD;
    end
  end

endmodule

// File: tb/tb_ksz_bus_master.sv
// Directed bench for ksz_bus_master: default-timing instance plus a slow-strobe
// instance, each with a tiny chip model that drives SD while RDN is low.
module tb_ksz_bus_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rv0, rdy0, wr0, rspv0, err0, cmd0, rdn0, wrn0;
  logic [7:0]  a0;
  logic [15:0] wd0, rd0, model0;
  wire  [15:0] sd0;
  logic        rv1, rdy1, wr1, rspv1, err1, cmd1, rdn1, wrn1;
  logic [7:0]  a1;
  logic [15:0] wd1, rd1, model1;
  wire  [15:0] sd1;

  assign sd0 = !rdn0 ? model0 : 'z;
  assign sd1 = !rdn1 ? model1 : 'z;

  ksz_bus_master u_dut0 (
    .clk40m(clk), .reset(reset), .req_valid(rv0), .req_ready(rdy0), .req_write(wr0),
    .req_addr(a0), .req_wdata(wd0), .rsp_valid(rspv0), .rsp_rdata(rd0), .rsp_err(err0),
    .CMD(cmd0), .RDN(rdn0), .WRN(wrn0), .SD(sd0)
  );

  ksz_bus_master #(.STROBE_CYC(4), .RECOVER_CYC(2), .GAP_CYC(1)) u_dut1 (
    .clk40m(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1), .req_write(wr1),
    .req_addr(a1), .req_wdata(wd1), .rsp_valid(rspv1), .rsp_rdata(rd1), .rsp_err(err1),
    .CMD(cmd1), .RDN(rdn1), .WRN(wrn1), .SD(sd1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus-rule monitor: strobes never both low, and nothing fights the chip while RDN=0.
  always @(negedge clk) begin
    if (!reset) begin
      if (!rdn0 && !wrn0) viol++;
      if (!rdn1 && !wrn1) viol++;
      if (!rdn0 && sd0 !== model0) viol++;
      if (!rdn1 && sd1 !== model1) viol++;
    end
  end

  // Per-cycle traces, bit/index i = cycle i after the accepting edge.
  logic [31:0] t_wl, t_rl, t_cl, t_rv, t_re, t_rdy;
  logic [15:0] t_sd [0:31];
  logic [15:0] t_rd [0:31];

  task automatic sample(input int d, input int i);
    if (d == 0) begin
      t_wl[i] = !wrn0; t_rl[i] = !rdn0; t_cl[i] = !cmd0;
      t_rv[i] = rspv0; t_re[i] = err0;  t_rdy[i] = rdy0;
      t_sd[i] = sd0;   t_rd[i] = rd0;
    end else begin
      t_wl[i] = !wrn1; t_rl[i] = !rdn1; t_cl[i] = !cmd1;
      t_rv[i] = rspv1; t_re[i] = err1;  t_rdy[i] = rdy1;
      t_sd[i] = sd1;   t_rd[i] = rd1;
    end
  endtask

  task automatic issue(input int d, input logic wr, input logic [7:0] a,
                       input logic [15:0] wd, input bit hold);
    @(negedge clk);
    if (d == 0) begin
      wr0 = wr; a0 = a; wd0 = wd; rv0 = 1'b1;
      check("ready_before_accept", {31'd0, rdy0}, 32'd1);
    end else begin
      wr1 = wr; a1 = a; wd1 = wd; rv1 = 1'b1;
      check("ready_before_accept1", {31'd0, rdy1}, 32'd1);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (d == 0) rv0 = 1'b0; else rv1 = 1'b0;
    end
  endtask

  task automatic capture(input int d, input int n);
    t_wl = '0; t_rl = '0; t_cl = '0; t_rv = '0; t_re = '0; t_rdy = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      sample(d, i);
    end
  endtask

  int rvc;

  initial begin
    rv0 = 1'b0; wr0 = 1'b0; a0 = '0; wd0 = '0; model0 = 16'h0000;
    rv1 = 1'b0; wr1 = 1'b0; a1 = '0; wd1 = '0; model1 = 16'h0000;
    reset = 1'b1;

    // Reset state; a request presented during reset must be ignored.
    rv0 = 1'b1; a0 = 8'h10; wr0 = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_pins", {26'd0, cmd0, rdn0, wrn0, rspv0, err0, rdy0}, 32'b111001);
    check("reset_rdata", {16'd0, rd0}, 32'h0);
    rv0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Write 0x10 = 0x89AB
    issue(0, 1'b1, 8'h10, 16'h89AB, 1'b0);
    capture(0, 9);
    check("wr_wrn_low", t_wl, 32'h36);
    check("wr_rdn_low", t_rl, 32'h0);
    check("wr_cmd_low", t_cl & 32'h3E, 32'h30);
    check("wr_sd_cmd1", {16'd0, t_sd[1]}, 32'h3010);
    check("wr_sd_cmd3", {16'd0, t_sd[3]}, 32'h3010);
    check("wr_sd_dat4", {16'd0, t_sd[4]}, 32'h89AB);
    check("wr_rsp_valid", t_rv, 32'h80);
    check("wr_rsp_err", t_re, 32'h0);
    check("wr_ready", t_rdy, 32'h300);

    // Read 0xC0, chip returns 0x8872
    model0 = 16'h8872;
    issue(0, 1'b0, 8'hC0, 16'h0000, 1'b0);
    capture(0, 9);
    check("rdC0_wrn_low", t_wl, 32'h6);
    check("rdC0_rdn_low", t_rl, 32'h30);
    check("rdC0_sd_cmd", {16'd0, t_sd[1]}, 32'h30C0);
    check("rdC0_sd_chip", {16'd0, t_sd[4]}, 32'h8872);
    check("rdC0_rsp_valid", t_rv, 32'h80);
    check("rdC0_rdata", {16'd0, t_rd[7]}, 32'h8872);
    check("rdC0_rsp_err", t_re, 32'h0);

    // Read 0x12, upper byte-enables, chip returns 0x4567
    model0 = 16'h4567;
    issue(0, 1'b0, 8'h12, 16'h0000, 1'b0);
    capture(0, 9);
    check("rd12_sd_cmd", {16'd0, t_sd[1]}, 32'hC012);
    check("rd12_rdata_old", {16'd0, t_rd[5]}, 32'h8872);
    check("rd12_rdata_cap", {16'd0, t_rd[6]}, 32'h4567);
    check("rd12_rdata", {16'd0, t_rd[7]}, 32'h4567);

    // Odd address rejected without bus activity
    issue(0, 1'b1, 8'h13, 16'hFFFF, 1'b0);
    capture(0, 9);
    check("odd_wrn_low", t_wl, 32'h0);
    check("odd_rdn_low", t_rl, 32'h0);
    check("odd_rsp_valid", t_rv, 32'h2);
    check("odd_rsp_err", t_re, 32'h2);
    check("odd_ready", t_rdy, 32'h3FC);
    check("odd_rdata_hold", {16'd0, t_rd[3]}, 32'h4567);

    // req_valid held high across two writes
    issue(0, 1'b1, 8'h10, 16'h89AB, 1'b1);
    a0 = 8'h22; wd0 = 16'h5555;
    capture(0, 9);
    check("b2b_wrn_low", t_wl, 32'h236);
    check("b2b_ready", t_rdy, 32'h100);
    check("b2b_sd_second", {16'd0, t_sd[9]}, 32'hC022);
    rv0 = 1'b0;
    capture(0, 8);
    check("b2b_second_rsp", t_rv, 32'h40);
    check("b2b_second_ready", t_rdy, 32'h180);

    // Reset pulsed in cycle 4 of a write
    issue(0, 1'b1, 8'h10, 16'h89AB, 1'b0);
    repeat (4) @(negedge clk);
    check("rst_pre_wrn_low", {31'd0, !wrn0}, 32'd1);
    #2 reset = 1'b1;
    #1 check("rst_async_pins", {28'd0, wrn0, rdn0, cmd0, rdy0}, 32'hF);
    @(negedge clk);
    reset = 1'b0;
    rvc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rspv0) rvc++;
    end
    check("rst_no_rsp", rvc, 32'd0);
    issue(0, 1'b1, 8'h10, 16'h89AB, 1'b0);
    capture(0, 9);
    check("rst_fresh_wrn_low", t_wl, 32'h36);
    check("rst_fresh_rsp", t_rv, 32'h80);
    check("rst_fresh_sd", {16'd0, t_sd[4]}, 32'h89AB);

    // Slow instance: STROBE_CYC=4, RECOVER_CYC=2
    issue(1, 1'b1, 8'h22, 16'h1234, 1'b0);
    capture(1, 14);
    check("slow_wrn_low", t_wl, 32'h79E);
    check("slow_sd_cmd", {16'd0, t_sd[5]}, 32'hC022);
    check("slow_sd_dat", {16'd0, t_sd[7]}, 32'h1234);
    check("slow_rsp_valid", t_rv, 32'h2000);
    check("slow_ready", t_rdy, 32'h4000);

    check("bus_rule_violations", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
